// File: rtl/ppc_types.sv
// Shared decode, opcode and condition-register types for the logic execution unit.
package ppc_types;

   typedef enum logic [3:0] {
      LOG_AND                      = 4'd0,
      LOG_OR                       = 4'd1,
      LOG_XOR                      = 4'd2,
      LOG_NAND                     = 4'd3,
      LOG_NOR                      = 4'd4,
      LOG_EQUIVALENT               = 4'd5,
      LOG_AND_WITH_COMPLEMENT      = 4'd6,
      LOG_OR_WITH_COMPLEMENT       = 4'd7,
      LOG_EXTEND_SIGN_BYTE         = 4'd8,
      LOG_EXTEND_SIGN_HALFWORD     = 4'd9,
      LOG_COUNT_LEADING_ZEROS_WORD = 4'd10,
      LOG_POPULATION_COUNT_BYTE    = 4'd11
   } log_op_t;

   typedef struct packed {
      log_op_t operation;
      logic    alter_cr0;
   } log_decode_t;

   // cr0[0:3] = LT, GT, EQ, SO
   typedef struct packed {
      logic [0:3] cr0;
      logic       cr0_valid;
      logic       so;
      logic [0:2] xer;
      logic       xer_valid;
   } cond_exception_t;

   function automatic logic [0:3] make_cr0(input logic lt, input logic eq, input logic so);
      return {lt, !lt && !eq, eq, so};
   endfunction

endpackage

// File: rtl/log_cntlz.sv
// Combinational leading-zero counter (bit 0 = MSB): per-16-bit group encoders feeding a group-level priority pick.
module log_cntlz #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [0:DATA_WIDTH-1]              value,
   output logic [$clog2(DATA_WIDTH+1)-1:0]    count
);

   localparam int NG = DATA_WIDTH / 16;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic [NG-1:0] grp_any;
   logic [3:0]    grp_lz [NG];

   function automatic logic [3:0] lz16(input logic [0:15] x);
      logic [3:0] r;
      r = 4'd0;
      for (int b = 15; b >= 0; b--) begin
         if (x[b]) r = 4'(b);
      end
      return r;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_group
         assign grp_any[gi] = |value[16*gi +: 16];
         assign grp_lz[gi]  = lz16(value[16*gi +: 16]);
      end
   endgenerate

   // The most significant non-empty group wins; an all-zero operand reports DATA_WIDTH.
   always_comb begin
      count = CW'(DATA_WIDTH);
      for (int g = NG - 1; g >= 0; g--) begin
         if (grp_any[g]) count = CW'(16 * g + int'(grp_lz[g]));
      end
   end

endmodule

// File: rtl/log_unit_pipe.sv
// Pipelined logical execution unit with valid/ready on both sides and synchronous flush.
// Optional per-byte popcount is built when LOG_UNIT_POPCNT_EN is defined.
module log_unit_pipe
   import ppc_types::*;
#(
   parameter int RS_ID_WIDTH = 5,
   parameter int DATA_WIDTH  = 32,
   parameter int STAGES      = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [RS_ID_WIDTH-1:0] rs_id_in,
   input  logic [4:0]             result_reg_addr_in,
   input  logic [0:DATA_WIDTH-1]  op1,
   input  logic [0:DATA_WIDTH-1]  op2,
   input  logic                   so,
   input  log_decode_t            control,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [RS_ID_WIDTH-1:0] rs_id_out,
   output logic [4:0]             result_reg_addr_out,
   output logic [0:DATA_WIDTH-1]  result,
   output cond_exception_t        cr0_xer
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef struct packed {
      logic [0:DATA_WIDTH-1]  op1;
      logic [0:DATA_WIDTH-1]  op2;
      log_decode_t            control;
      logic                   so;
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             addr;
   } s0_t;

   typedef struct packed {
      logic [0:DATA_WIDTH-1]  and_res;
      logic [0:DATA_WIDTH-1]  or_res;
      logic [0:DATA_WIDTH-1]  xor_res;
      logic [0:DATA_WIDTH-1]  nand_res;
      logic [0:DATA_WIDTH-1]  nor_res;
      logic [0:DATA_WIDTH-1]  eqv_res;
      logic [0:DATA_WIDTH-1]  andc_res;
      logic [0:DATA_WIDTH-1]  orc_res;
      logic [0:DATA_WIDTH-1]  extsb_res;
      logic [0:DATA_WIDTH-1]  extsh_res;
      logic [0:DATA_WIDTH-1]  cntlz_res;
`ifdef LOG_UNIT_POPCNT_EN
      logic [0:DATA_WIDTH-1]  popcnt_res;
`endif
      log_decode_t            control;
      logic                   so;
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             addr;
   } s1_t;

   typedef struct packed {
      logic [0:DATA_WIDTH-1]  result;
      cond_exception_t        cr0_xer;
      logic [RS_ID_WIDTH-1:0] rs_id;
      logic [4:0]             addr;
   } out_t;

   logic [0:STAGES-1] v_reg;
   logic [0:STAGES-1] en;
   s0_t               s0_reg;
   s1_t               s1_reg, s1_next;
   out_t              s2_next;
   out_t              pipe_reg [2:STAGES-1];
   logic [CW-1:0]     cntlz_count;
   logic [0:DATA_WIDTH-1] res_mux;

   genvar gi;

   // Stage i may advance unless it and everything downstream is full and the CDB is stalled.
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_en
         assign en[gi] = output_ready | ~(&v_reg[gi:STAGES-1]);
      end
   endgenerate

   assign input_ready = en[0];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         v_reg <= '0;
      end else begin
         if (en[0]) v_reg[0] <= input_valid;
         for (int i = 1; i < STAGES; i++) begin
            if (en[i]) v_reg[i] <= v_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_reg <= '0;
      end else if (en[0]) begin
         s0_reg <= '{op1, op2, control, so, rs_id_in, result_reg_addr_in};
      end
   end

   log_cntlz #(.DATA_WIDTH(DATA_WIDTH)) u_cntlz (
      .value (s0_reg.op1),
      .count (cntlz_count)
   );

`ifdef LOG_UNIT_POPCNT_EN
   logic [0:DATA_WIDTH-1] popcnt_bytes;
   generate
      for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_popcnt
         assign popcnt_bytes[8*gi +: 8] = 8'($countones(s0_reg.op1[8*gi +: 8]));
      end
   endgenerate
`endif

   always_comb begin
      s1_next           = '0;
      s1_next.and_res   = s0_reg.op1 & s0_reg.op2;
      s1_next.or_res    = s0_reg.op1 | s0_reg.op2;
      s1_next.xor_res   = s0_reg.op1 ^ s0_reg.op2;
      s1_next.nand_res  = ~(s0_reg.op1 & s0_reg.op2);
      s1_next.nor_res   = ~(s0_reg.op1 | s0_reg.op2);
      s1_next.eqv_res   = ~(s0_reg.op1 ^ s0_reg.op2);
      s1_next.andc_res  = s0_reg.op1 & ~s0_reg.op2;
      s1_next.orc_res   = s0_reg.op1 | ~s0_reg.op2;
      s1_next.extsb_res = {{(DATA_WIDTH-8){s0_reg.op1[DATA_WIDTH-8]}}, s0_reg.op1[DATA_WIDTH-8 +: 8]};
      s1_next.extsh_res = {{(DATA_WIDTH-16){s0_reg.op1[DATA_WIDTH-16]}}, s0_reg.op1[DATA_WIDTH-16 +: 16]};
      s1_next.cntlz_res = DATA_WIDTH'(cntlz_count);
`ifdef LOG_UNIT_POPCNT_EN
      s1_next.popcnt_res = popcnt_bytes;
`endif
      s1_next.control   = s0_reg.control;
      s1_next.so        = s0_reg.so;
      s1_next.rs_id     = s0_reg.rs_id;
      s1_next.addr      = s0_reg.addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= '0;
      end else if (en[1]) begin
         s1_reg <= s1_next;
      end
   end

   always_comb begin
      res_mux = '0;
      case (s1_reg.control.operation)
         LOG_AND:                      res_mux = s1_reg.and_res;
         LOG_OR:                       res_mux = s1_reg.or_res;
         LOG_XOR:                      res_mux = s1_reg.xor_res;
         LOG_NAND:                     res_mux = s1_reg.nand_res;
         LOG_NOR:                      res_mux = s1_reg.nor_res;
         LOG_EQUIVALENT:               res_mux = s1_reg.eqv_res;
         LOG_AND_WITH_COMPLEMENT:      res_mux = s1_reg.andc_res;
         LOG_OR_WITH_COMPLEMENT:       res_mux = s1_reg.orc_res;
         LOG_EXTEND_SIGN_BYTE:         res_mux = s1_reg.extsb_res;
         LOG_EXTEND_SIGN_HALFWORD:     res_mux = s1_reg.extsh_res;
         LOG_COUNT_LEADING_ZEROS_WORD: res_mux = s1_reg.cntlz_res;
`ifdef LOG_UNIT_POPCNT_EN
         LOG_POPULATION_COUNT_BYTE:    res_mux = s1_reg.popcnt_res;
`endif
         default:                      res_mux = '0;
      endcase
   end

   always_comb begin
      s2_next                   = '0;
      s2_next.result            = res_mux;
      s2_next.cr0_xer.cr0       = make_cr0(res_mux[0], res_mux == '0, s1_reg.so);
      s2_next.cr0_xer.cr0_valid = s1_reg.control.alter_cr0;
      s2_next.cr0_xer.so        = s1_reg.so;
      s2_next.rs_id             = s1_reg.rs_id;
      s2_next.addr              = s1_reg.addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_reg[2] <= '0;
      end else if (en[2]) begin
         pipe_reg[2] <= s2_next;
      end
   end

   // Extra stages only add latency; they carry the finished stage-2 payload unchanged.
   generate
      for (gi = 3; gi < STAGES; gi++) begin : g_delay
         always_ff @(posedge clk) begin
            if (rst) begin
               pipe_reg[gi] <= '0;
            end else if (en[gi]) begin
               pipe_reg[gi] <= pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign output_valid        = v_reg[STAGES-1];
   assign result              = pipe_reg[STAGES-1].result;
   assign cr0_xer             = pipe_reg[STAGES-1].cr0_xer;
   assign rs_id_out           = pipe_reg[STAGES-1].rs_id;
   assign result_reg_addr_out = pipe_reg[STAGES-1].addr;

endmodule

// File: tb/tb_log_unit_pipe.sv
// Directed bench for log_unit_pipe: a 32-bit/3-stage instance and a 64-bit/5-stage instance.
module tb_log_unit_pipe;
   import ppc_types::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, flush, input_valid, input_ready, so, output_valid, output_ready;
   logic [4:0]      rs_id_in, rs_id_out, addr_in, addr_out;
   logic [0:31]     op1, op2, result;
   log_decode_t     control;
   cond_exception_t cr0_xer;

   logic            flush5, valid5, ready5, so5, ovalid5, oready5;
   logic [4:0]      rs5_in, rs5_out, addr5_out;
   logic [0:63]     op1_5, op2_5, result5;
   log_decode_t     control5;
   cond_exception_t cr5;

   int errors = 0;
   int checks = 0;

   log_unit_pipe #(.RS_ID_WIDTH(5), .DATA_WIDTH(32), .STAGES(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(input_valid), .input_ready(input_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(addr_in),
      .op1(op1), .op2(op2), .so(so), .control(control),
      .output_valid(output_valid), .output_ready(output_ready),
      .rs_id_out(rs_id_out), .result_reg_addr_out(addr_out),
      .result(result), .cr0_xer(cr0_xer)
   );

   log_unit_pipe #(.RS_ID_WIDTH(5), .DATA_WIDTH(64), .STAGES(5)) dut5 (
      .clk(clk), .rst(rst), .flush(flush5),
      .input_valid(valid5), .input_ready(ready5),
      .rs_id_in(rs5_in), .result_reg_addr_in(5'd9),
      .op1(op1_5), .op2(op2_5), .so(so5), .control(control5),
      .output_valid(ovalid5), .output_ready(oready5),
      .rs_id_out(rs5_out), .result_reg_addr_out(addr5_out),
      .result(result5), .cr0_xer(cr5)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input log_op_t op, input logic [0:31] a, input logic [0:31] b,
                         input logic alt, input logic s, input logic [0:31] exp_res,
                         input logic [3:0] exp_cr0, input string tag);
      int n;
      n = 0;
      control.operation = op; control.alter_cr0 = alt;
      op1 = a; op2 = b; so = s; rs_id_in = 5'd7; addr_in = 5'd3; input_valid = 1'b1;
      do begin
         @(posedge clk); #1;
         input_valid = 1'b0;
         n++;
      end while (!output_valid && n < 10);
      check({tag, " latency"}, 64'(n), 64'd3);
      check({tag, " result"}, 64'(result), 64'(exp_res));
      check({tag, " cr0"}, 64'(cr0_xer.cr0), 64'(exp_cr0));
      check({tag, " cr0_valid"}, 64'(cr0_xer.cr0_valid), 64'(alt));
      $display("op %s: result=%h cr0=%b latency=%0d", tag, result, cr0_xer.cr0, n);
   endtask

   task automatic run_op5(input log_op_t op, input logic [0:63] a, input logic [0:63] exp_res,
                          input logic [3:0] exp_cr0, input string tag);
      int n;
      n = 0;
      control5.operation = op; control5.alter_cr0 = 1'b1;
      op1_5 = a; op2_5 = 64'hFFFF_FFFF_FFFF_FFFF; rs5_in = 5'd21; valid5 = 1'b1;
      do begin
         @(posedge clk); #1;
         valid5 = 1'b0;
         n++;
      end while (!ovalid5 && n < 12);
      check({tag, " latency"}, 64'(n), 64'd5);
      check({tag, " result"}, 64'(result5), exp_res);
      check({tag, " cr0"}, 64'(cr5.cr0), 64'(exp_cr0));
      check({tag, " tag"}, 64'(rs5_out), 64'd21);
      $display("op5 %s: result=%h cr0=%b latency=%0d", tag, result5, cr5.cr0, n);
   endtask

   initial begin
      int got, first_cyc, last_cyc, acc, rises, expect_id;
      logic held_set, will_accept;
      logic [0:31] held_res;
      logic [4:0]  held_id;

      rst = 1'b1; flush = 1'b0; input_valid = 1'b0; so = 1'b0; output_ready = 1'b1;
      rs_id_in = '0; addr_in = '0; op1 = '0; op2 = '0; control = '{LOG_AND, 1'b0};
      flush5 = 1'b0; valid5 = 1'b0; so5 = 1'b0; oready5 = 1'b1; rs5_in = '0;
      op1_5 = '0; op2_5 = '0; control5 = '{LOG_AND, 1'b0};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset output_valid", 64'(output_valid), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset cr0_xer", 64'(cr0_xer), 64'd0);
      check("reset input_ready", 64'(input_ready), 64'd1);
      check("reset5 output_valid", 64'(ovalid5), 64'd0);
      $display("reset: output_valid=%b input_ready=%b result=%h", output_valid, input_ready, result);

      // Basic operations, hand-computed
      run_op(LOG_AND, 32'hF0F0_0000, 32'hFF00_0000, 1'b1, 1'b0, 32'hF000_0000, 4'b1000, "and");
      check("and addr", 64'(addr_out), 64'd3);
      check("and xer", 64'({cr0_xer.xer, cr0_xer.xer_valid}), 64'd0);
      run_op(LOG_OR,   32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 32'h0000_00FF, 4'b0100, "or");
      run_op(LOG_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 4'b0011, "nand so");
      run_op(LOG_NOR,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1000, "nor");
      run_op(LOG_EQUIVALENT, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1000, "eqv");
      run_op(LOG_AND_WITH_COMPLEMENT, 32'h0000_00FF, 32'h0000_000F, 1'b1, 1'b0, 32'h0000_00F0, 4'b0100, "andc");
      run_op(LOG_OR_WITH_COMPLEMENT, 32'h0000_0000, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0000_FFFF, 4'b0100, "orc");
      run_op(LOG_COUNT_LEADING_ZEROS_WORD, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'd32, 4'b0100, "cntlz 0");
      run_op(LOG_COUNT_LEADING_ZEROS_WORD, 32'h0000_8000, 32'h0, 1'b1, 1'b0, 32'd16, 4'b0100, "cntlz 8000");
      run_op(LOG_COUNT_LEADING_ZEROS_WORD, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'd0, 4'b0010, "cntlz msb");
      run_op(LOG_EXTEND_SIGN_BYTE, 32'h0000_0080, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 4'b1000, "extsb");
      run_op(LOG_EXTEND_SIGN_HALFWORD, 32'h1234_8000, 32'h0, 1'b1, 1'b0, 32'hFFFF_8000, 4'b1000, "extsh");
      run_op(log_op_t'(4'd14), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 4'b0010, "unknown op");
`ifdef LOG_UNIT_POPCNT_EN
      run_op(LOG_POPULATION_COUNT_BYTE, 32'hFF01_0300, 32'h0, 1'b1, 1'b0, 32'h0801_0200, 4'b0100, "popcnt");
`else
      run_op(LOG_POPULATION_COUNT_BYTE, 32'hFF01_0300, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0010, "popcnt off");
`endif

      // Back-to-back issue: 8 results on consecutive cycles, tags in order
      @(posedge clk); #1;
      got = 0; first_cyc = -1; last_cyc = -1;
      control = '{LOG_XOR, 1'b0}; op2 = 32'h0000_00A5;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc < 8) begin
            check("b2b input_ready", 64'(input_ready), 64'd1);
            input_valid = 1'b1; rs_id_in = 5'(cyc); op1 = 32'(cyc);
         end else begin
            input_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (output_valid) begin
            check("b2b tag", 64'(rs_id_out), 64'(got));
            check("b2b result", 64'(result), 64'(got ^ 32'hA5));
            $display("b2b: cycle=%0d tag=%0d result=%h", cyc, rs_id_out, result);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
      end
      input_valid = 1'b0;
      check("b2b count", 64'(got), 64'd8);
      check("b2b contiguous", 64'(last_cyc - first_cyc), 64'd7);

      // Backpressure: continuous issue against a stalled CDB
      output_ready = 1'b0; acc = 0; held_set = 1'b0; held_res = '0; held_id = '0;
      op2 = 32'h0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         input_valid = 1'b1; rs_id_in = 5'(16 + acc); op1 = 32'(16 + acc);
         will_accept = input_ready;
         @(posedge clk); #1;
         if (will_accept) acc++;
         if (output_valid) begin
            if (!held_set) begin
               held_set = 1'b1; held_res = result; held_id = rs_id_out;
            end else begin
               check("stall hold result", 64'(result), 64'(held_res));
               check("stall hold tag", 64'(rs_id_out), 64'(held_id));
            end
         end
      end
      input_valid = 1'b0;
      $display("stall: accepted=%0d input_ready=%b output_valid=%b tag=%0d", acc, input_ready, output_valid, rs_id_out);
      check("stall accepted", 64'(acc), 64'd3);
      check("stall input_ready", 64'(input_ready), 64'd0);
      check("stall output_valid", 64'(output_valid), 64'd1);
      check("stall head tag", 64'(rs_id_out), 64'd16);
      output_ready = 1'b1; expect_id = 16;
      for (int n = 0; n < 8; n++) begin
         if (output_valid) begin
            check("drain tag", 64'(rs_id_out), 64'(expect_id));
            check("drain result", 64'(result), 64'(expect_id));
            $display("drain: tag=%0d result=%h", rs_id_out, result);
            expect_id++;
         end
         @(posedge clk); #1;
      end
      check("drain count", 64'(expect_id), 64'd19);

      // 64-bit, 5-stage instance
      run_op5(LOG_COUNT_LEADING_ZEROS_WORD, 64'h0, 64'd64, 4'b0100, "cntlz64 0");
      run_op5(LOG_EXTEND_SIGN_HALFWORD, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_8000, 4'b1000, "extsh64");

      // Flush with three in flight plus an issue in the flush cycle
      @(posedge clk); #1;
      rises = 0; control5 = '{LOG_OR, 1'b0}; op1_5 = 64'h1; op2_5 = 64'h0;
      for (int i = 1; i <= 3; i++) begin
         valid5 = 1'b1; rs5_in = 5'(i);
         @(posedge clk); #1;
         if (ovalid5) rises++;
      end
      valid5 = 1'b1; rs5_in = 5'd4; flush5 = 1'b1;
      @(posedge clk); #1;
      flush5 = 1'b0; valid5 = 1'b0;
      if (ovalid5) rises++;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (ovalid5) rises++;
      end
      $display("flush: output_valid rises=%0d input_ready=%b", rises, ready5);
      check("flush no output", 64'(rises), 64'd0);
      check("flush input_ready", 64'(ready5), 64'd1);
      run_op5(LOG_AND, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1000, "post flush and");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
